// File: rtl/kairo_busarb_pkg.sv
// Shared types and constants for the Kairo two-master bus arbiter.
package kairo_busarb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef logic [0:0] mst_idx_t;

  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/kairo_busarb_rr.sv
// Combinational 2-way round-robin picker: on a tie the master that was not
// served last wins; otherwise the only requester wins.
module kairo_busarb_rr
  import kairo_busarb_pkg::*;
(
  input  logic [1:0] req,
  input  mst_idx_t   last,
  output logic       gnt_valid,
  output mst_idx_t   gnt_idx
);

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = req[1];
    if (&req) gnt_idx = ~last;
  end

endmodule

// File: rtl/kairo_busarb.sv
// Two-master, one-slave valid/ready arbiter with round-robin grant held until
// completion and a BUSY watchdog that converts a hung slave into an error.
module kairo_busarb
  import kairo_busarb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            M0_VALID,
  output logic            M0_READY,
  input  logic [DW/8-1:0] M0_WSTB,
  input  logic [AW-1:0]   M0_ADDR,
  input  logic [DW-1:0]   M0_WDATA,
  output logic [DW-1:0]   M0_RDATA,
  output logic            M0_EXCPT,
  input  logic            M1_VALID,
  output logic            M1_READY,
  input  logic [DW/8-1:0] M1_WSTB,
  input  logic [AW-1:0]   M1_ADDR,
  input  logic [DW-1:0]   M1_WDATA,
  output logic [DW-1:0]   M1_RDATA,
  output logic            M1_EXCPT,
  output logic            S_VALID,
  input  logic            S_READY,
  output logic [DW/8-1:0] S_WSTB,
  output logic [AW-1:0]   S_ADDR,
  output logic [DW-1:0]   S_WDATA,
  input  logic [DW-1:0]   S_RDATA,
  input  logic            S_EXCPT
);

  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam bit            WDOG_EN = (TIMEOUT != 0);

  arb_state_t    state;
  mst_idx_t      grant;
  mst_idx_t      last;
  logic [CW-1:0] cnt;

  logic          gnt_valid;
  mst_idx_t      gnt_idx;
  logic          busy;
  logic          m_valid;
  logic          live;
  logic          timeout_hit;
  logic          resp;
  logic          resp_excpt;
  logic [DW-1:0] resp_rdata;

  kairo_busarb_rr u_rr (
    .req       ({M1_VALID, M0_VALID}),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Outputs are gated by RST_N so a reset mid-transaction drops S_VALID and
  // suppresses READY in the same cycle, before the reset edge lands.
  always_comb begin
    busy        = (state == ARB_BUSY);
    m_valid     = (grant == 1'b1) ? M1_VALID : M0_VALID;
    live        = busy && m_valid && RST_N;
    timeout_hit = WDOG_EN && busy && (cnt == CNT_MAX);
    resp        = live && (timeout_hit || S_READY);
    resp_excpt  = timeout_hit ? 1'b1 : S_EXCPT;
    resp_rdata  = timeout_hit ? '0 : S_RDATA;

    S_VALID  = live && !timeout_hit;
    S_WSTB   = (grant == 1'b1) ? M1_WSTB  : M0_WSTB;
    S_ADDR   = (grant == 1'b1) ? M1_ADDR  : M0_ADDR;
    S_WDATA  = (grant == 1'b1) ? M1_WDATA : M0_WDATA;

    M0_READY = resp && (grant == 1'b0);
    M1_READY = resp && (grant == 1'b1);
    M0_EXCPT = M0_READY && resp_excpt;
    M1_EXCPT = M1_READY && resp_excpt;
    M0_RDATA = M0_READY ? resp_rdata : '0;
    M1_RDATA = M1_READY ? resp_rdata : '0;
  end

  // NOTE: state registers use non-blocking assignments only, and reset is
  // sampled on the clock edge (synchronous), not in the sensitivity list.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= ARB_IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (gnt_valid) begin
            grant <= gnt_idx;
            cnt   <= '0;
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // A master withdrawing its request aborts without touching last.
          if (!m_valid) begin
            state <= ARB_IDLE;
          end else if (resp) begin
            last  <= grant;
            state <= ARB_IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kairo_busarb.sv
// Directed self-checking bench for kairo_busarb (watchdog TIMEOUT = 8).
module tb_kairo_busarb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            M0_VALID, M1_VALID, M0_READY, M1_READY;
  logic [DW/8-1:0] M0_WSTB, M1_WSTB, S_WSTB;
  logic [AW-1:0]   M0_ADDR, M1_ADDR, S_ADDR;
  logic [DW-1:0]   M0_WDATA, M1_WDATA, S_WDATA;
  logic [DW-1:0]   M0_RDATA, M1_RDATA, S_RDATA;
  logic            M0_EXCPT, M1_EXCPT;
  logic            S_VALID, S_READY, S_EXCPT;

  int n_checks = 0;
  int n_errors = 0;

  kairo_busarb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .M0_VALID(M0_VALID), .M0_READY(M0_READY), .M0_WSTB(M0_WSTB),
    .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA), .M0_RDATA(M0_RDATA), .M0_EXCPT(M0_EXCPT),
    .M1_VALID(M1_VALID), .M1_READY(M1_READY), .M1_WSTB(M1_WSTB),
    .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA), .M1_RDATA(M1_RDATA), .M1_EXCPT(M1_EXCPT),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_WSTB(S_WSTB), .S_ADDR(S_ADDR),
    .S_WDATA(S_WDATA), .S_RDATA(S_RDATA), .S_EXCPT(S_EXCPT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0;
    M0_VALID = 1'b0; M0_WSTB = '0; M0_ADDR = '0; M0_WDATA = '0;
    M1_VALID = 1'b0; M1_WSTB = '0; M1_ADDR = '0; M1_WDATA = '0;
    S_READY = 1'b0; S_RDATA = '0; S_EXCPT = 1'b0;

    // Reset state, with requests present to show outputs stay quiet.
    tick(); tick();
    M0_VALID = 1'b1; M1_VALID = 1'b1; S_READY = 1'b1; S_RDATA = 32'h1111_2222;
    settle();
    check("rst_s_valid",  32'(S_VALID),  0);
    check("rst_m0_ready", 32'(M0_READY), 0);
    check("rst_m1_ready", 32'(M1_READY), 0);
    check("rst_m0_excpt", 32'(M0_EXCPT), 0);
    check("rst_m1_excpt", 32'(M1_EXCPT), 0);
    check("rst_m0_rdata", M0_RDATA, 0);
    check("rst_m1_rdata", M1_RDATA, 0);
    M0_VALID = 1'b0; M1_VALID = 1'b0; S_READY = 1'b0; S_RDATA = '0;
    tick();
    RST_N = 1'b1;
    tick();

    // Single M0 read, slave answers 3 cycles after S_VALID.
    M0_ADDR = 32'h0000_0100; M0_WSTB = 4'h0; M0_VALID = 1'b1;
    settle();
    check("t1_idle_svalid", 32'(S_VALID), 0);
    tick(); settle();
    check("t1_svalid", 32'(S_VALID), 1);
    check("t1_saddr",  S_ADDR, 32'h0000_0100);
    check("t1_swstb",  32'(S_WSTB), 0);
    check("t1_wait0",  32'(M0_READY), 0);
    tick(); settle(); check("t1_wait1", 32'(M0_READY), 0);
    tick(); settle(); check("t1_wait2", 32'(M0_READY), 0);
    tick();
    S_READY = 1'b1; S_RDATA = 32'hDEAD_BEEF;
    settle();
    check("t1_m0_ready", 32'(M0_READY), 1);
    check("t1_m0_rdata", M0_RDATA, 32'hDEAD_BEEF);
    check("t1_m0_excpt", 32'(M0_EXCPT), 0);
    check("t1_m1_ready", 32'(M1_READY), 0);
    check("t1_m1_rdata", M1_RDATA, 0);
    tick();
    S_READY = 1'b0; M0_VALID = 1'b0;
    settle();
    check("t1_after_ready", 32'(M0_READY), 0);
    check("t1_after_svalid", 32'(S_VALID), 0);

    // Fresh reset, then both masters request continuously: M0, M1, M0, M1.
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    M0_ADDR = 32'h0000_1000; M1_ADDR = 32'h0000_2000;
    M0_VALID = 1'b1; M1_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      S_READY = 1'b1; S_RDATA = 32'(i + 16);
      settle();
      check("t2_svalid", 32'(S_VALID), 1);
      check("t2_saddr",  S_ADDR, (i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
      check("t2_m0_ready", 32'(M0_READY), (i % 2 == 0) ? 1 : 0);
      check("t2_m1_ready", 32'(M1_READY), (i % 2 == 0) ? 0 : 1);
      tick();
      S_READY = 1'b0;
      settle();
      check("t2_gap_svalid", 32'(S_VALID), 0);
      check("t2_gap_ready", 32'({M1_READY, M0_READY}), 0);
    end
    M0_VALID = 1'b0; M1_VALID = 1'b0;

    // M1 write: forwarded fields, READY coincident with S_READY.
    M1_WSTB = 4'hF; M1_ADDR = 32'h8002_0000; M1_WDATA = 32'h0000_00FF; M1_VALID = 1'b1;
    tick(); settle();
    check("t3_svalid", 32'(S_VALID), 1);
    check("t3_swstb",  32'(S_WSTB), 32'hF);
    check("t3_saddr",  S_ADDR, 32'h8002_0000);
    check("t3_swdata", S_WDATA, 32'h0000_00FF);
    check("t3_wait",   32'(M1_READY), 0);
    tick();
    S_READY = 1'b1;
    settle();
    check("t3_m1_ready", 32'(M1_READY), 1);
    check("t3_m0_ready", 32'(M0_READY), 0);
    check("t3_swstb_hold", 32'(S_WSTB), 32'hF);
    tick();
    S_READY = 1'b0; M1_VALID = 1'b0; M1_WSTB = '0;

    // Watchdog: slave never answers, error response 9 cycles after request.
    M0_ADDR = 32'h0000_0300; M0_VALID = 1'b1; S_RDATA = 32'hA5A5_A5A5;
    for (int i = 1; i <= TO; i++) begin
      tick(); settle();
      check("t4_wait_ready",  32'(M0_READY), 0);
      check("t4_wait_svalid", 32'(S_VALID), 1);
    end
    tick(); settle();
    check("t4_to_ready",  32'(M0_READY), 1);
    check("t4_to_excpt",  32'(M0_EXCPT), 1);
    check("t4_to_rdata",  M0_RDATA, 0);
    check("t4_to_svalid", 32'(S_VALID), 0);
    tick();
    M0_VALID = 1'b0;
    tick();
    S_READY = 1'b1;
    settle();
    check("t4_late_m0", 32'(M0_READY), 0);
    check("t4_late_m1", 32'(M1_READY), 0);
    check("t4_late_excpt", 32'(M0_EXCPT), 0);
    tick();
    S_READY = 1'b0; S_RDATA = '0;

    // Reset while BUSY with M1 granted; next tie must go to M0.
    M1_ADDR = 32'h0000_4000; M1_VALID = 1'b1;
    tick(); settle();
    check("t5_busy_m1", S_ADDR, 32'h0000_4000);
    tick();
    RST_N = 1'b0; S_READY = 1'b1;
    settle();
    check("t5_rst_svalid", 32'(S_VALID), 0);
    check("t5_rst_m1_ready", 32'(M1_READY), 0);
    tick();
    RST_N = 1'b1; S_READY = 1'b0;
    M0_ADDR = 32'h0000_5000; M0_VALID = 1'b1;
    settle();
    check("t5_idle_svalid", 32'(S_VALID), 0);
    tick(); settle();
    check("t5_tie_m0", S_ADDR, 32'h0000_5000);
    S_READY = 1'b1;
    settle();
    check("t5_m0_ready", 32'(M0_READY), 1);
    check("t5_m1_ready", 32'(M1_READY), 0);
    tick();
    S_READY = 1'b0; M0_VALID = 1'b0; M1_VALID = 1'b0;

    // Slave error is forwarded, and does not stick to the next transfer.
    M0_ADDR = 32'h0000_0600; M0_VALID = 1'b1;
    tick();
    S_READY = 1'b1; S_EXCPT = 1'b1; S_RDATA = 32'h0000_1234;
    settle();
    check("t6_err_ready", 32'(M0_READY), 1);
    check("t6_err_excpt", 32'(M0_EXCPT), 1);
    check("t6_err_rdata", M0_RDATA, 32'h0000_1234);
    tick();
    S_READY = 1'b0; S_EXCPT = 1'b0;
    tick();
    S_READY = 1'b1; S_RDATA = 32'h0000_5678;
    settle();
    check("t6_ok_ready", 32'(M0_READY), 1);
    check("t6_ok_excpt", 32'(M0_EXCPT), 0);
    check("t6_ok_rdata", M0_RDATA, 32'h0000_5678);
    tick();
    S_READY = 1'b0; M0_VALID = 1'b0;

    // M1 withdraws mid-transfer: no READY, and last (M0) is kept.
    M1_ADDR = 32'h0000_0800; M1_VALID = 1'b1;
    tick(); settle();
    check("t7_svalid", 32'(S_VALID), 1);
    M1_VALID = 1'b0; S_READY = 1'b1;
    settle();
    check("t7_abort_svalid", 32'(S_VALID), 0);
    check("t7_abort_ready", 32'(M1_READY), 0);
    tick();
    S_READY = 1'b0;
    M0_ADDR = 32'h0000_0700; M0_VALID = 1'b1; M1_VALID = 1'b1;
    tick(); settle();
    check("t7_tie_m1", S_ADDR, 32'h0000_0800);
    S_READY = 1'b1;
    settle();
    check("t7_m1_ready", 32'(M1_READY), 1);
    check("t7_m0_ready", 32'(M0_READY), 0);
    tick();
    S_READY = 1'b0; M0_VALID = 1'b0; M1_VALID = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
